ltpi_link_align_ctrl: RTL and testbench
=======================================

// Module: ltpi_link_align_ctrl
// PURPOSE
// - Frame-alignment controller for the LTPI receive path. Sits between the LVDS deserializer and link training FSM.
// - Hunts for the frame boundary by issuing bitslip pulses to the deserializer.
// - Qualifies alignment over consecutive good frames, asserts link_aligned, and drops it after consecutive bad frames.
// PARAMETERS
// - ALIGN_CNT      default 7    consecutive good frames required to declare alignment (1..255)
// - LOST_CNT       default 3    consecutive bad frames in ALIGNED that drop alignment (1..255)
// - SLIP_WAIT_CYC  default 4    clk cycles to wait after a bitslip before sampling frames (1..255)
// - SLIP_MAX       default 10   bitslips per hunt round before hunt_timeout pulses (1..255)
// PORTS
// - clk            in   1   receive-domain clock
// - reset          in   1   synchronous, active-high reset
// - enable         in   1   0 forces HUNT; no bitslips are issued
// - frm_valid      in   1   one-cycle strobe at each deserialized frame boundary
// - frm_comma_ok   in   1   comma symbol is correct for this frame; qualified by frm_valid
// - frm_crc_ok     in   1   CRC is correct for this frame; qualified by frm_valid
// - bitslip        out  1   one-cycle pulse that requests a 1-bit slip
// - link_aligned   out  1   level; high while in ALIGNED
// - align_lost     out  1   one-cycle pulse on the ALIGNED->HUNT transition
// - hunt_timeout   out  1   one-cycle pulse when a SLIP_MAX round finishes without alignment
// - state_o        out  2   0=HUNT 1=SLIP_WAIT 2=CHECK 3=ALIGNED
// BEHAVIOUR
// - Reset: state=HUNT; all counters 0; bitslip=0, link_aligned=0, align_lost=0, hunt_timeout=0.
// - A good frame is frm_valid & frm_comma_ok & frm_crc_ok. A bad frame is frm_valid & ~(comma_ok & crc_ok).
// - Cycles with frm_valid=0 are ignored in every state.
// - HUNT:
//   - enable=1 and a good frame: good_cnt=1 and go to CHECK. If ALIGN_CNT==1, go directly to ALIGNED.
//   - enable=1 and a bad frame: pulse bitslip in the next cycle, increment slip_cnt, go to SLIP_WAIT.
//   - When slip_cnt reaches SLIP_MAX, pulse hunt_timeout in the same cycle as that bitslip, then clear slip_cnt.
// - SLIP_WAIT: wait_cnt counts to SLIP_WAIT_CYC, then go to HUNT. Any frm_valid during this wait is ignored.
// - CHECK:
//   - A good frame increments good_cnt. When good_cnt reaches ALIGN_CNT, go to ALIGNED.
//   - A bad frame clears good_cnt, pulses bitslip, and goes to SLIP_WAIT.
// - ALIGNED:
//   - link_aligned=1, registered, rising 1 cycle after the entry frame. slip_cnt is cleared on entry.
//   - A good frame clears bad_cnt. A bad frame increments bad_cnt.
//   - When bad_cnt reaches LOST_CNT, go to HUNT, pulse align_lost, and drop link_aligned in the same cycle.
//   - Bitslip is never issued in ALIGNED.
// - enable falling, from any state: go to HUNT next cycle, clear counters, deassert link_aligned.
//   - align_lost pulses only if the previous state was ALIGNED.
// - Counters are 8-bit and saturate; they never wrap.
// - reset mid-operation, including during a bitslip pulse: reset wins and all outputs clear next cycle.
// - bitslip pulses are spaced at least SLIP_WAIT_CYC+1 cycles apart.
// CONFIGURATION
// - LTPI_ALIGN_STATS_EN defined adds these output ports:
//   - slip_total[15:0]: count of bitslips issued
//   - lost_total[15:0]: count of align_lost pulses
//   - bad_frm_total[15:0]: count of bad frames seen in ALIGNED
//   - All three saturate at 16'hFFFF and clear on reset only.
// - LTPI_ALIGN_STATS_EN undefined: these ports and their counters are absent; all other behaviour is identical.
// TESTING
// - Default params, enable=1, 7 good frames: link_aligned=1 one cycle after the 7th frm_valid; bitslip never pulses.
// - 3 bad frames, then 7 good frames: exactly 3 bitslip pulses, each at least 5 clk apart; then ALIGNED.
// - In ALIGNED: bad, good, bad, bad frames -> stays aligned. A 3rd consecutive bad frame -> align_lost pulses once and link_aligned=0.
// - Only bad frames for 10 slips: hunt_timeout pulses with the 10th bitslip; slip_cnt restarts and the 11th slip gives no timeout.
// - enable dropped in ALIGNED: next cycle state_o=0, link_aligned=0, align_lost=1.
// - reset asserted in CHECK with good_cnt=5: all outputs 0. Alignment then needs a full 7 good frames.
// - With LTPI_ALIGN_STATS_EN defined: the scenario of 3 slips plus 1 loss reads slip_total=3, lost_total=1.

Source files
------------

// File: rtl/ltpi_link_align_ctrl.sv
// LTPI receive frame aligner: bitslip hunt, qualification over good frames, loss on bad frames; LTPI_ALIGN_STATS_EN adds stat counters.
// Latency: all outputs registered, one cycle after the deciding frame; no backpressure (frames are strobes and are never stalled).
module ltpi_link_align_ctrl #(
    parameter int ALIGN_CNT     = 7,
    parameter int LOST_CNT      = 3,
    parameter int SLIP_WAIT_CYC = 4,
    parameter int SLIP_MAX      = 10
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        enable_i,
    input  logic        frm_valid_i,
    input  logic        frm_comma_ok_i,
    input  logic        frm_crc_ok_i,
    output logic        bitslip_o,
    output logic        link_aligned_o,
    output logic        align_lost_o,
    output logic        hunt_timeout_o,
    output logic [1:0]  state_o
`ifdef LTPI_ALIGN_STATS_EN
    ,
    output logic [15:0] slip_total_o,
    output logic [15:0] lost_total_o,
    output logic [15:0] bad_frm_total_o
`endif
);

    typedef enum logic [1:0] {
        ST_HUNT      = 2'd0,
        ST_SLIP_WAIT = 2'd1,
        ST_CHECK     = 2'd2,
        ST_ALIGNED   = 2'd3
    } state_t;

    localparam logic [7:0] ALIGN_C = 8'(ALIGN_CNT);
    localparam logic [7:0] LOST_C  = 8'(LOST_CNT);
    localparam logic [7:0] WAIT_C  = 8'(SLIP_WAIT_CYC);
    localparam logic [7:0] SLIP_C  = 8'(SLIP_MAX);

    state_t     state_q, state_d;
    logic [7:0] good_cnt_q, good_cnt_d;
    logic [7:0] bad_cnt_q, bad_cnt_d;
    logic [7:0] slip_cnt_q, slip_cnt_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       bitslip_q, bitslip_d;
    logic       align_lost_q, align_lost_d;
    logic       hunt_timeout_q, hunt_timeout_d;
    logic       link_aligned_q;
    logic       good_frm, bad_frm, slip_req;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign good_frm = frm_valid_i & frm_comma_ok_i & frm_crc_ok_i;
    assign bad_frm  = frm_valid_i & ~(frm_comma_ok_i & frm_crc_ok_i);

    always_comb begin
        state_d        = state_q;
        good_cnt_d     = good_cnt_q;
        bad_cnt_d      = bad_cnt_q;
        slip_cnt_d     = slip_cnt_q;
        wait_cnt_d     = wait_cnt_q;
        bitslip_d      = 1'b0;
        align_lost_d   = 1'b0;
        hunt_timeout_d = 1'b0;
        slip_req       = 1'b0;
        if (!enable_i) begin
            state_d      = ST_HUNT;
            good_cnt_d   = 8'd0;
            bad_cnt_d    = 8'd0;
            slip_cnt_d   = 8'd0;
            wait_cnt_d   = 8'd0;
            align_lost_d = (state_q == ST_ALIGNED);
        end else begin
            case (state_q)
                ST_HUNT: begin
                    if (good_frm) begin
                        good_cnt_d = 8'd1;
                        bad_cnt_d  = 8'd0;
                        if (ALIGN_C <= 8'd1) begin
                            state_d    = ST_ALIGNED;
                            slip_cnt_d = 8'd0;
                        end else begin
                            state_d = ST_CHECK;
                        end
                    end else if (bad_frm) begin
                        slip_req = 1'b1;
                    end
                end
                ST_SLIP_WAIT: begin
                    wait_cnt_d = sat_inc(wait_cnt_q);
                    if (wait_cnt_d >= WAIT_C) begin
                        wait_cnt_d = 8'd0;
                        state_d    = ST_HUNT;
                    end
                end
                ST_CHECK: begin
                    if (good_frm) begin
                        good_cnt_d = sat_inc(good_cnt_q);
                        if (good_cnt_d >= ALIGN_C) begin
                            state_d    = ST_ALIGNED;
                            slip_cnt_d = 8'd0;
                            bad_cnt_d  = 8'd0;
                        end
                    end else if (bad_frm) begin
                        good_cnt_d = 8'd0;
                        slip_req   = 1'b1;
                    end
                end
                default: begin
                    if (good_frm) begin
                        bad_cnt_d = 8'd0;
                    end else if (bad_frm) begin
                        bad_cnt_d = sat_inc(bad_cnt_q);
                        if (bad_cnt_d >= LOST_C) begin
                            state_d      = ST_HUNT;
                            align_lost_d = 1'b1;
                            good_cnt_d   = 8'd0;
                            bad_cnt_d    = 8'd0;
                        end
                    end
                end
            endcase
        end
        // Every slip, from HUNT or CHECK, counts toward the hunt round.
        if (slip_req) begin
            bitslip_d  = 1'b1;
            state_d    = ST_SLIP_WAIT;
            wait_cnt_d = 8'd0;
            slip_cnt_d = sat_inc(slip_cnt_q);
            if (slip_cnt_d >= SLIP_C) begin
                hunt_timeout_d = 1'b1;
                slip_cnt_d     = 8'd0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= ST_HUNT;
            good_cnt_q     <= 8'd0;
            bad_cnt_q      <= 8'd0;
            slip_cnt_q     <= 8'd0;
            wait_cnt_q     <= 8'd0;
            bitslip_q      <= 1'b0;
            align_lost_q   <= 1'b0;
            hunt_timeout_q <= 1'b0;
            link_aligned_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            good_cnt_q     <= good_cnt_d;
            bad_cnt_q      <= bad_cnt_d;
            slip_cnt_q     <= slip_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
            bitslip_q      <= bitslip_d;
            align_lost_q   <= align_lost_d;
            hunt_timeout_q <= hunt_timeout_d;
            link_aligned_q <= (state_d == ST_ALIGNED);
        end
    end

    assign bitslip_o      = bitslip_q;
    assign link_aligned_o = link_aligned_q;
    assign align_lost_o   = align_lost_q;
    assign hunt_timeout_o = hunt_timeout_q;
    assign state_o        = state_q;

`ifdef LTPI_ALIGN_STATS_EN
    logic [15:0] slip_total_q, lost_total_q, bad_frm_total_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            slip_total_q    <= 16'd0;
            lost_total_q    <= 16'd0;
            bad_frm_total_q <= 16'd0;
        end else begin
            if (bitslip_q && slip_total_q != 16'hFFFF)
                slip_total_q <= slip_total_q + 16'd1;
            if (align_lost_q && lost_total_q != 16'hFFFF)
                lost_total_q <= lost_total_q + 16'd1;
            if (enable_i && bad_frm && state_q == ST_ALIGNED && bad_frm_total_q != 16'hFFFF)
                bad_frm_total_q <= bad_frm_total_q + 16'd1;
        end
    end

    assign slip_total_o    = slip_total_q;
    assign lost_total_o    = lost_total_q;
    assign bad_frm_total_o = bad_frm_total_q;
`endif

endmodule

// File: tb/tb_ltpi_link_align_ctrl.sv
// Directed bench for ltpi_link_align_ctrl with default parameters; inputs driven and outputs sampled on the falling edge.
module tb_ltpi_link_align_ctrl;

    logic       clk_i = 1'b0;
    logic       reset_i, enable_i, frm_valid_i, frm_comma_ok_i, frm_crc_ok_i;
    logic       bitslip_o, link_aligned_o, align_lost_o, hunt_timeout_o;
    logic [1:0] state_o;
`ifdef LTPI_ALIGN_STATS_EN
    logic [15:0] slip_total_o, lost_total_o, bad_frm_total_o;
`endif

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int slip_seen = 0;
    int lost_seen = 0;
    int last_slip = -1;
    int min_gap = 1000;

    ltpi_link_align_ctrl dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .enable_i       (enable_i),
        .frm_valid_i    (frm_valid_i),
        .frm_comma_ok_i (frm_comma_ok_i),
        .frm_crc_ok_i   (frm_crc_ok_i),
        .bitslip_o      (bitslip_o),
        .link_aligned_o (link_aligned_o),
        .align_lost_o   (align_lost_o),
        .hunt_timeout_o (hunt_timeout_o),
        .state_o        (state_o)
`ifdef LTPI_ALIGN_STATS_EN
        ,
        .slip_total_o   (slip_total_o),
        .lost_total_o   (lost_total_o),
        .bad_frm_total_o(bad_frm_total_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        cyc = cyc + 1;
        if (bitslip_o) begin
            if (last_slip >= 0 && (cyc - last_slip) < min_gap)
                min_gap = cyc - last_slip;
            last_slip = cyc;
            slip_seen = slip_seen + 1;
        end
        if (align_lost_o)
            lost_seen = lost_seen + 1;
    end

    task automatic check(input string tag, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // kind: 0 = good, 1 = bad comma, 2 = bad crc
    task automatic send(input int kind);
        frm_valid_i    = 1'b1;
        frm_comma_ok_i = (kind != 1);
        frm_crc_ok_i   = (kind != 2);
        @(negedge clk_i);
        frm_valid_i    = 1'b0;
        frm_comma_ok_i = 1'b0;
        frm_crc_ok_i   = 1'b0;
    endtask

    int slips0, lost0;

    initial begin
        reset_i = 1'b1;
        enable_i = 1'b0;
        frm_valid_i = 1'b0;
        frm_comma_ok_i = 1'b0;
        frm_crc_ok_i = 1'b0;
        tick(3);
        check("rst_state", state_o, 0);
        check("rst_aligned", link_aligned_o, 0);
        check("rst_bitslip", bitslip_o, 0);
        check("rst_lost", align_lost_o, 0);
        check("rst_timeout", hunt_timeout_o, 0);
        reset_i = 1'b0;
        enable_i = 1'b1;
        tick(1);

        // Clean alignment on 7 good frames
        for (int i = 0; i < 6; i++) send(0);
        check("t1_state_check", state_o, 2);
        check("t1_not_aligned", link_aligned_o, 0);
        send(0);
        check("t1_aligned", link_aligned_o, 1);
        check("t1_state_aligned", state_o, 3);
        check("t1_no_slip", slip_seen, 0);

        // Loss needs LOST_CNT consecutive bad frames
        send(1); send(0); send(2); send(1);
        check("t3_still_aligned", link_aligned_o, 1);
        check("t3_state", state_o, 3);
        send(2);
        check("t3_lost_pulse", align_lost_o, 1);
        check("t3_dropped", link_aligned_o, 0);
        check("t3_state_hunt", state_o, 0);
        tick(2);
        check("t3_lost_once", lost_seen, 1);
        check("t3_no_slip_aligned", slip_seen, 0);

        // Three slips at minimum spacing, then align
        slips0 = slip_seen;
        for (int i = 0; i < 3; i++) begin
            send(2);
            check("t2_slip_pulse", bitslip_o, 1);
            check("t2_slip_wait", state_o, 1);
            tick(4);
        end
        for (int i = 0; i < 7; i++) send(0);
        check("t2_slip_count", slip_seen - slips0, 3);
        check("t2_min_gap", min_gap, 5);
        check("t2_aligned", link_aligned_o, 1);
        check("t2_no_timeout", hunt_timeout_o, 0);
`ifdef LTPI_ALIGN_STATS_EN
        check("st_slip_total", slip_total_o, 3);
        check("st_lost_total", lost_total_o, 1);
        check("st_bad_total", bad_frm_total_o, 4);
`endif

        // enable dropped while aligned
        lost0 = lost_seen;
        enable_i = 1'b0;
        tick(1);
        check("t5_state", state_o, 0);
        check("t5_aligned", link_aligned_o, 0);
        check("t5_lost", align_lost_o, 1);
        enable_i = 1'b1;
        tick(1);
        check("t5_lost_clear", align_lost_o, 0);
        check("t5_lost_once", lost_seen - lost0, 1);

        // Hunt timeout on the 10th slip only
        for (int i = 0; i < 11; i++) begin
            send(1);
            check("t4_slip", bitslip_o, 1);
            check("t4_timeout", hunt_timeout_o, (i == 9) ? 1 : 0);
            tick(4);
        end
        check("t4_min_gap", min_gap, 5);

        // Reset in CHECK with good_cnt=5
        for (int i = 0; i < 5; i++) send(0);
        check("t6_in_check", state_o, 2);
        reset_i = 1'b1;
        tick(1);
        check("t6_rst_state", state_o, 0);
        check("t6_rst_aligned", link_aligned_o, 0);
        check("t6_rst_slip", bitslip_o, 0);
        check("t6_rst_lost", align_lost_o, 0);
        check("t6_rst_timeout", hunt_timeout_o, 0);
        reset_i = 1'b0;
        send(2);
        check("t6_slip_before_rst", bitslip_o, 1);
        reset_i = 1'b1;
        tick(1);
        check("t6_rst_kills_slip", bitslip_o, 0);
        check("t6_rst_state2", state_o, 0);
        reset_i = 1'b0;
        tick(1);
        for (int i = 0; i < 6; i++) send(0);
        check("t6_six_not_aligned", link_aligned_o, 0);
        send(0);
        check("t6_seven_aligned", link_aligned_o, 1);

        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
